// File: rtl/avalon_fp_mult_pipe.sv
// Avalon-MM slave around a pipelined floating-point multiplier.
// Operations are issued from OP1/OP2 and their results and flags are
// returned through an in-order result queue. The outstanding count
// (in flight plus queued) is capped at DEPTH by stalling further STARTs.
module avalon_fp_mult_pipe #(
  parameter int E     = 7,
  parameter int M     = 8,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_s1_address,
  input  logic        avs_s1_read,
  input  logic        avs_s1_write,
  input  logic [15:0] avs_s1_writedata,
  output logic [15:0] avs_s1_readdata,
  output logic        avs_s1_waitrequest
);

  localparam int W  = 1 + E + M;
  localparam int AW = $clog2(DEPTH);
  localparam int RW = W + 3;

  localparam logic [E+1:0] EB_W    = (E+2)'(2**(E-1) - 1);
  localparam logic [E+1:0] OVF_W   = (E+2)'((2**(E-1) - 1) + (2**E - 1));
  localparam logic [E-1:0] MAX_E   = '1;
  localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    A_OP1    = 3'd0,
    A_OP2    = 3'd1,
    A_START  = 3'd2,
    A_RES    = 3'd3,
    A_STATUS = 3'd4,
    A_COUNT  = 3'd5,
    A_CLEAR  = 3'd6
  } reg_addr_t;

  typedef enum logic [2:0] {
    CODE_NORMAL = 3'd0,
    CODE_OVF    = 3'd1,
    CODE_UNF    = 3'd2,
    CODE_ZERO   = 3'd3,
    CODE_NAN    = 3'd4
  } code_t;

  logic [W-1:0]  op1, op2;
  logic [AW:0]   outstanding;
  logic          underrun;

  logic          s0_valid;
  logic [W-1:0]  s0_a, s0_b;
  logic [RW-1:0] s0_res;

  logic          push_valid;
  logic [RW-1:0] push_data;
  logic          push;

  logic [RW-1:0] q_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   q_count;
  logic          q_empty, full, busy;
  logic [RW-1:0] head;

  logic stall_start, stall_read;
  logic accept_wr, accept_rd;
  logic issue, pop, clear, underrun_set;

  // Bus decode: stalls, accepted transactions and the actions they trigger
  assign q_empty = (q_count == '0);
  assign full    = (outstanding == DEPTH_W);
  assign busy    = (outstanding != '0);
  assign head    = q_mem[rd_ptr];

  assign stall_start = avs_s1_write && (avs_s1_address == A_START) &&
                       avs_s1_writedata[0] && full;
  assign stall_read  = avs_s1_read &&
                       ((avs_s1_address == A_RES) || (avs_s1_address == A_STATUS)) &&
                       q_empty && busy;
  assign avs_s1_waitrequest = stall_start | stall_read;

  assign accept_wr    = avs_s1_write & ~avs_s1_waitrequest;
  assign accept_rd    = avs_s1_read  & ~avs_s1_waitrequest;
  assign issue        = accept_wr && (avs_s1_address == A_START) && avs_s1_writedata[0];
  assign clear        = accept_wr && (avs_s1_address == A_CLEAR);
  assign pop          = accept_rd && (avs_s1_address == A_RES) && !q_empty;
  assign underrun_set = accept_rd && (avs_s1_address == A_RES) && q_empty;

  // Operand registers; only ever written by the bus, never stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op1 <= '0;
      op2 <= '0;
    end else if (accept_wr) begin
      if (avs_s1_address == A_OP1) op1 <= avs_s1_writedata[W-1:0];
      if (avs_s1_address == A_OP2) op2 <= avs_s1_writedata[W-1:0];
    end
  end

  // Stage 0 snapshots the operands so later OP writes cannot disturb the op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else begin
      s0_valid <= issue;
      if (issue) begin
        s0_a <= op1;
        s0_b <= op2;
      end
    end
  end

  logic            sign;
  logic [E-1:0]    ex, ey;
  logic [M-1:0]    mx, my;
  logic [2*M+1:0]  ma_ext, mb_ext, prod;
  logic            shift;
  logic [M-1:0]    mant;
  logic [E+1:0]    esum, exp_norm;
  logic            is_nan, is_zero, is_unf, is_ovf;
  logic [W-1:0]    res;
  code_t           code;
  logic            unused_bits;

  // Multiply with truncation and flag classification, evaluated on stage 0
  always_comb begin
    sign     = s0_a[W-1] ^ s0_b[W-1];
    ex       = s0_a[W-2:M];
    ey       = s0_b[W-2:M];
    mx       = s0_a[M-1:0];
    my       = s0_b[M-1:0];
    ma_ext   = {{(M+1){1'b0}}, 1'b1, mx};
    mb_ext   = {{(M+1){1'b0}}, 1'b1, my};
    prod     = ma_ext * mb_ext;
    shift    = prod[2*M+1];
    mant     = shift ? prod[2*M:M+1] : prod[2*M-1:M];
    esum     = {2'b00, ex} + {2'b00, ey} + {{(E+1){1'b0}}, shift};
    exp_norm = esum - EB_W;
    is_nan   = ((ex == MAX_E) && (mx != '0)) || ((ey == MAX_E) && (my != '0));
    is_zero  = ((ex == '0) && (mx == '0)) || ((ey == '0) && (my == '0));
    is_unf   = (ex == '0) || (ey == '0) || (esum <= EB_W);
    is_ovf   = (esum >= OVF_W) || (ex == MAX_E) || (ey == MAX_E);
    res      = {sign, exp_norm[E-1:0], mant};
    code     = CODE_NORMAL;
    if (is_nan) begin
      res  = {sign, MAX_E, mant};
      code = CODE_NAN;
    end else if (is_zero) begin
      res  = '0;
      code = CODE_ZERO;
    end else if (is_unf) begin
      res  = {sign, {E{1'b0}}, {{(M-1){1'b0}}, 1'b1}};
      code = CODE_UNF;
    end else if (is_ovf) begin
      res  = {sign, MAX_E, {M{1'b0}}};
      code = CODE_OVF;
    end
    s0_res      = {res, code};
    unused_bits = ^{prod[M-1:0], exp_norm[E+1:E]};
  end

  generate
    if (LAT > 1) begin : g_pipe
      logic [LAT-2:0] pv;
      logic [RW-1:0]  pd [LAT-1];

      // Valid bits of the result delay line; a flush empties it
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pv <= '0;
        end else begin
          pv[0] <= s0_valid & ~clear;
          for (int i = 1; i < LAT - 1; i++) pv[i] <= pv[i-1] & ~clear;
        end
      end

      // Result payload shifts along with its valid bit
      always_ff @(posedge clk) begin
        pd[0] <= s0_res;
        for (int i = 1; i < LAT - 1; i++) pd[i] <= pd[i-1];
      end

      assign push_valid = pv[LAT-2];
      assign push_data  = pd[LAT-2];
    end else begin : g_nopipe
      assign push_valid = s0_valid;
      assign push_data  = s0_res;
    end
  endgenerate

  assign push = push_valid & ~clear;

  // Result queue storage
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= push_data;
  end

  // Queue pointers and occupancy; a flush beats a same-edge push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (AW+1)'(1);
        2'b01:   q_count <= q_count - (AW+1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Outstanding ops (in flight plus queued) and the sticky underrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      underrun    <= 1'b0;
    end else if (clear) begin
      outstanding <= '0;
      underrun    <= 1'b0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + (AW+1)'(1);
        2'b01:   outstanding <= outstanding - (AW+1)'(1);
        default: outstanding <= outstanding;
      endcase
      if (underrun_set) underrun <= 1'b1;
    end
  end

  // Read data mux; zero whenever no read is presented
  always_comb begin
    avs_s1_readdata = '0;
    if (avs_s1_read) begin
      case (avs_s1_address)
        A_OP1:    avs_s1_readdata = 16'(op1);
        A_OP2:    avs_s1_readdata = 16'(op2);
        A_START:  avs_s1_readdata = {13'b0, busy, full, q_empty};
        A_RES:    if (!q_empty) avs_s1_readdata = 16'(head[RW-1:3]);
        A_STATUS: avs_s1_readdata = {11'b0, underrun, 1'b0, (q_empty ? 3'b000 : head[2:0])};
        A_COUNT:  avs_s1_readdata = 16'(outstanding);
        default:  avs_s1_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_fp_mult_pipe.sv
// Bench for avalon_fp_mult_pipe: directed scenarios with literal
// expectations plus randomized bus traffic, all checked every cycle
// against a timestamped result-queue model of the peripheral.
module tb_avalon_fp_mult_pipe;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_s1_address = '0;
  logic        avs_s1_read = 1'b0;
  logic        avs_s1_write = 1'b0;
  logic [15:0] avs_s1_writedata = '0;
  logic [15:0] avs_s1_readdata;
  logic        avs_s1_waitrequest;

  int checks = 0;
  int errors = 0;

  avalon_fp_mult_pipe #(.E(7), .M(8), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .avs_s1_address     (avs_s1_address),
    .avs_s1_read        (avs_s1_read),
    .avs_s1_write       (avs_s1_write),
    .avs_s1_writedata   (avs_s1_writedata),
    .avs_s1_readdata    (avs_s1_readdata),
    .avs_s1_waitrequest (avs_s1_waitrequest)
  );

  initial forever #5 clk = ~clk;

  // Reference arithmetic: {code, result} from plain integer math
  function automatic logic [18:0] fp_ref(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, prod, sh, es, mant;
    logic s;
    ea = int'(a[14:8]);
    eb = int'(b[14:8]);
    ma = int'(a[7:0]);
    mb = int'(b[7:0]);
    s  = a[15] ^ b[15];
    prod = (256 + ma) * (256 + mb);
    sh   = (prod >= 131072) ? 1 : 0;
    mant = (sh == 1) ? (prod / 512) % 256 : (prod / 256) % 256;
    es   = ea + eb + sh;
    if ((ea == 127 && ma != 0) || (eb == 127 && mb != 0)) return {3'd4, s, 7'h7F, 8'(mant)};
    if ((ea == 0 && ma == 0) || (eb == 0 && mb == 0))     return {3'd3, 16'h0000};
    if (ea == 0 || eb == 0 || es <= 63)                   return {3'd2, s, 7'h00, 8'h01};
    if (es - 63 >= 127 || ea == 127 || eb == 127)         return {3'd1, s, 7'h7F, 8'h00};
    return {3'd0, s, 7'(es - 63), 8'(mant)};
  endfunction

  // Model: every outstanding op with the cycle its result becomes visible
  typedef struct {
    logic [18:0] val;
    int          ready;
  } entry_t;

  entry_t      m_q[$];
  logic [15:0] m_op1 = '0;
  logic [15:0] m_op2 = '0;
  logic        m_underrun = 1'b0;
  int          cyc = 0;
  bit          m_acc;

  function automatic bit head_ready();
    return (m_q.size() > 0) && (m_q[0].ready <= cyc);
  endfunction

  function automatic bit model_wait();
    return (avs_s1_write && avs_s1_address == 3'd2 && avs_s1_writedata[0] && m_q.size() == DEPTH) ||
           (avs_s1_read && (avs_s1_address == 3'd3 || avs_s1_address == 3'd4) &&
            !head_ready() && m_q.size() > 0);
  endfunction

  function automatic logic [15:0] model_rd();
    if (!avs_s1_read) return 16'h0000;
    case (avs_s1_address)
      3'd0: return m_op1;
      3'd1: return m_op2;
      3'd2: return {13'b0, m_q.size() != 0, m_q.size() == DEPTH, !head_ready()};
      3'd3: return head_ready() ? m_q[0].val[15:0] : 16'h0000;
      3'd4: return {11'b0, m_underrun, 1'b0, head_ready() ? m_q[0].val[18:16] : 3'b000};
      3'd5: return 16'(m_q.size());
      default: return 16'h0000;
    endcase
  endfunction

  // Model update on each clock edge, cleared immediately by reset
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_q.delete();
      m_op1      = '0;
      m_op2      = '0;
      m_underrun = 1'b0;
    end else begin
      m_acc = !model_wait();
      if (avs_s1_write && m_acc) begin
        case (avs_s1_address)
          3'd0: m_op1 = avs_s1_writedata;
          3'd1: m_op2 = avs_s1_writedata;
          3'd2: if (avs_s1_writedata[0]) m_q.push_back('{val: fp_ref(m_op1, m_op2), ready: cyc + 1 + LAT});
          3'd6: begin
            m_q.delete();
            m_underrun = 1'b0;
          end
          default: ;
        endcase
      end
      if (avs_s1_read && m_acc && avs_s1_address == 3'd3) begin
        if (head_ready()) void'(m_q.pop_front());
        else m_underrun = 1'b1;
      end
      cyc++;
    end
  end

  // Compare process: waitrequest and readdata against the model every cycle
  initial forever begin
    @(negedge clk);
    checks++;
    if (avs_s1_waitrequest !== model_wait()) begin
      errors++;
      $display("[TB] FAIL waitrequest t=%0t addr=%0d got %0b want %0b",
               $time, avs_s1_address, avs_s1_waitrequest, model_wait());
    end
    if (!(avs_s1_read && model_wait())) begin
      checks++;
      if (avs_s1_readdata !== model_rd()) begin
        errors++;
        $display("[TB] FAIL readdata t=%0t addr=%0d got %h want %h",
                 $time, avs_s1_address, avs_s1_readdata, model_rd());
      end
    end
  end

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One bus transaction, held until accepted or the cycle budget runs out
  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [15:0] d,
                          output logic [15:0] rv, output int waits);
    bit done;
    avs_s1_address   = a;
    avs_s1_writedata = d;
    avs_s1_read      = !wr;
    avs_s1_write     = wr;
    waits = 0;
    rv    = '0;
    done  = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (!avs_s1_waitrequest) begin
        rv   = avs_s1_readdata;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL bus_timeout addr=%0d got stalled want accepted", a);
    end
    @(posedge clk);
    #1;
    avs_s1_read  = 1'b0;
    avs_s1_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    logic [15:0] rv;
    int w;
    bus_xfer(1'b1, a, d, rv, w);
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    int w;
    bus_xfer(1'b0, a, 16'h0000, v, w);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    wr(3'd0, a);
    wr(3'd1, b);
    wr(3'd2, 16'h0001);
  endtask

  // Present a START while full for n cycles, then withdraw it
  task automatic hold_stall(input int n, output int waits);
    avs_s1_address   = 3'd2;
    avs_s1_writedata = 16'h0001;
    avs_s1_write     = 1'b1;
    waits = 0;
    repeat (n) begin
      @(negedge clk);
      if (avs_s1_waitrequest) waits++;
    end
    @(posedge clk);
    #1;
    avs_s1_write = 1'b0;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] specials [6];
    specials = '{16'h0000, 16'h8000, 16'h7F00, 16'h7F40, 16'h0040, 16'h3F00};
    case ($urandom_range(0, 9))
      0:       return 16'($urandom);
      1:       return specials[$urandom_range(0, 5)];
      default: return {1'($urandom), 7'($urandom_range(45, 82)), 8'($urandom)};
    endcase
  endfunction

  // Overall time limit
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] v;
  logic [18:0] r;
  int          w;
  logic [15:0] exp_res  [4];
  logic [15:0] exp_code [4];
  int          sel;

  initial begin
    exp_res  = '{16'h4020, 16'h4000, 16'h7F01, 16'h0000};
    exp_code = '{16'h0000, 16'h0000, 16'h0004, 16'h0003};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the reference arithmetic with hand-worked values
    r = fp_ref(16'h3F80, 16'h4000); check_output("pin_1p5x2", r[15:0], 16'h4080);
    check_output("pin_1p5x2_code", 16'(r[18:16]), 16'h0000);
    r = fp_ref(16'h3F80, 16'h3F80); check_output("pin_1p5sq", r[15:0], 16'h4020);
    r = fp_ref(16'h7E00, 16'h7E00); check_output("pin_ovf", r[15:0], 16'h7F00);
    check_output("pin_ovf_code", 16'(r[18:16]), 16'h0001);
    r = fp_ref(16'h0100, 16'h0100); check_output("pin_unf", r[15:0], 16'h0001);
    r = fp_ref(16'h7F01, 16'h3F00); check_output("pin_nan_code", 16'(r[18:16]), 16'h0004);

    // Reset state
    rd(3'd5, v); check_output("reset_count", v, 16'h0000);
    rd(3'd2, v); check_output("reset_start_reg", v, 16'h0001);
    rd(3'd0, v); check_output("reset_op1", v, 16'h0000);
    rd(3'd4, v); check_output("reset_status", v, 16'h0000);

    // Single op: count, status, result, count after pop
    issue(16'h3F80, 16'h4000);
    rd(3'd5, v); check_output("single_count", v, 16'h0001);
    rd(3'd4, v); check_output("single_status", v, 16'h0000);
    rd(3'd3, v); check_output("single_res", v, 16'h4080);
    rd(3'd5, v); check_output("single_count_after", v, 16'h0000);

    // RES read straight after START stalls exactly LAT cycles
    issue(16'h3F80, 16'h4000);
    bus_xfer(1'b0, 3'd3, 16'h0000, v, w);
    check_output("res_stall_cycles", 16'(w), 16'(LAT));
    check_output("res_stall_data", v, 16'h4080);
    rd(3'd5, v); check_output("res_stall_count", v, 16'h0000);

    // Four ops, results and codes in issue order
    issue(16'h3F80, 16'h3F80);
    issue(16'h3F00, 16'h4000);
    issue(16'h7F01, 16'h3F00);
    issue(16'h0000, 16'h4000);
    for (int i = 0; i < 4; i++) begin
      rd(3'd4, v); check_output("order_code", v, exp_code[i]);
      rd(3'd3, v); check_output("order_res", v, exp_res[i]);
    end

    // Fill to DEPTH with back-to-back STARTs, then stall the fifth
    wr(3'd0, 16'h3F80);
    wr(3'd1, 16'h4000);
    repeat (4) wr(3'd2, 16'h0001);
    rd(3'd2, v); check_output("full_start_reg", v, 16'h0006);
    rd(3'd5, v); check_output("full_count", v, 16'h0004);
    hold_stall(6, w); check_output("full_stall_cycles", 16'(w), 16'h0006);
    rd(3'd3, v); check_output("full_pop", v, 16'h4080);
    bus_xfer(1'b1, 3'd2, 16'h0001, v, w);
    check_output("fifth_accept_waits", 16'(w), 16'h0000);
    rd(3'd5, v); check_output("fifth_count", v, 16'h0004);
    wr(3'd6, 16'h0000);
    rd(3'd5, v); check_output("clear_count", v, 16'h0000);

    // Underrun is sticky until CLEAR
    rd(3'd3, v); check_output("underrun_res", v, 16'h0000);
    rd(3'd4, v); check_output("underrun_status", v, 16'h0010);
    wr(3'd6, 16'h0001);
    rd(3'd4, v); check_output("underrun_cleared", v, 16'h0000);
    rd(3'd5, v); check_output("underrun_count", v, 16'h0000);

    // Overflow, underflow and a negative product
    issue(16'h7E00, 16'h7E00);
    rd(3'd4, v); check_output("ovf_code", v, 16'h0001);
    rd(3'd3, v); check_output("ovf_res", v, 16'h7F00);
    issue(16'h0100, 16'h0100);
    rd(3'd4, v); check_output("unf_code", v, 16'h0002);
    rd(3'd3, v); check_output("unf_res", v, 16'h0001);
    issue(16'hBF80, 16'h4000);
    rd(3'd3, v); check_output("neg_res", v, 16'hC080);

    // Reset pulse while ops are in flight discards them
    issue(16'h3F80, 16'h4000);
    wr(3'd2, 16'h0001);
    #3 reset_n = 1'b0;
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd(3'd5, v); check_output("midreset_count", v, 16'h0000);
    rd(3'd2, v); check_output("midreset_start_reg", v, 16'h0001);
    rd(3'd0, v); check_output("midreset_op1", v, 16'h0000);
    repeat (LAT + 2) @(posedge clk);
    #1;
    rd(3'd5, v); check_output("midreset_count_late", v, 16'h0000);
    rd(3'd2, v); check_output("midreset_empty_late", v, 16'h0001);

    // Randomized traffic checked by the compare process
    for (int it = 0; it < 800; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 15) begin
        wr(3'd0, rand_op());
      end else if (sel < 30) begin
        wr(3'd1, rand_op());
      end else if (sel < 55) begin
        if (m_q.size() == DEPTH) rd(3'd3, v);
        else wr(3'd2, {15'($urandom), ($urandom_range(0, 9) != 0)});
      end else if (sel < 75) begin
        rd(3'd3, v);
      end else if (sel < 82) begin
        rd(3'd4, v);
      end else if (sel < 88) begin
        rd(3'($urandom_range(0, 7)), v);
      end else if (sel < 90) begin
        wr(3'd6, 16'($urandom));
      end else if (sel < 93) begin
        wr(3'($urandom_range(3, 7)) == 3'd6 ? 3'd7 : 3'($urandom_range(3, 5)), 16'($urandom));
      end else begin
        @(posedge clk);
        #1;
      end
    end

    repeat (LAT + 2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
